// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, FSM encoding and buffer payload for the fetch unit
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam int          BUF_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - 2-entry fall-through FIFO of {pc,instr} with flush
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         s_tvalid_i,
    input  fetch_entry_t s_tdata_i,
    output logic         m_tvalid_o,
    output fetch_entry_t m_tdata_o,
    input  logic         m_tready_i,
    output logic [1:0]   count_o
);
    fetch_entry_t mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         empty;
    logic         pop;
    logic         bypass;
    logic         push;
    logic         pop_store;

    // An arriving entry is presented straight away when nothing is stored ahead of it.
    assign empty      = (count_q == 2'd0);
    assign m_tvalid_o = !flush_i && (!empty || s_tvalid_i);
    assign m_tdata_o  = empty ? s_tdata_i : mem_q[rd_ptr_q];
    assign pop        = m_tvalid_o && m_tready_i;
    assign bypass     = empty && pop;
    assign push       = !flush_i && s_tvalid_i && !bypass;
    assign pop_store  = pop && !empty;
    assign count_o    = count_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_tdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_store) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop_store};
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch FSM with PC sequencing, redirect and decode handshake
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);
    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         in_flight_q;
    logic [31:0]  in_flight_pc_q;
    logic         misalign_q;
    logic [31:0]  fetch_count_q;
    logic         buf_valid;
    fetch_entry_t buf_data;
    fetch_entry_t rsp_entry;
    logic [1:0]   buf_count;
    logic         pop;
    logic         issue;
    logic [2:0]   pending;

    // A redirect flushes the buffer and blanks the response arriving in the same cycle.
    assign rsp_entry = '{pc: in_flight_pc_q, instr: imem_rdata};

    fetch_skid_buffer u_buf (
        .clk_i      (clk),
        .rst_i      (reset),
        .flush_i    (redirect_valid),
        .s_tvalid_i (in_flight_q),
        .s_tdata_i  (rsp_entry),
        .m_tvalid_o (buf_valid),
        .m_tdata_o  (buf_data),
        .m_tready_i (if_ready),
        .count_o    (buf_count)
    );

    assign pop     = buf_valid && if_ready;
    assign pending = {1'b0, buf_count} + {2'b00, in_flight_q} - {2'b00, pop};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (halt) state_d = ST_HALTED;
            ST_HALTED: if (!halt) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
        issue = (state_q == ST_RUN) && !halt && !redirect_valid && (pending < DEPTH);
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_BOOT;
            pc_q           <= RESET_PC;
            in_flight_q    <= 1'b0;
            in_flight_pc_q <= RESET_PC;
            misalign_q     <= 1'b0;
            fetch_count_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            in_flight_q   <= issue;
            if (issue) begin
                in_flight_pc_q <= pc_q;
            end
            misalign_q    <= misalign_q | (redirect_valid && (redirect_pc[1:0] != 2'b00));
            fetch_count_q <= fetch_count_q + {31'd0, pop};
        end
    end

    assign imem_rd_en   = issue;
    assign imem_addr    = pc_q;
    assign if_valid     = buf_valid;
    assign if_instr     = buf_valid ? buf_data.instr : NOP_INSTR;
    assign if_pc        = buf_valid ? buf_data.pc : 32'd0;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - randomized and directed check of fetch_controller against a queue model
module tb_fetch_controller;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int          total = 0;
    int          bad = 0;

    logic [31:0] q[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;
    int          m_state;

    logic        s_valid, s_rd, s_mis;
    logic [31:0] s_pc, s_instr, s_addr;

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata <= imem_rd_en ? (32'hA000_0000 | imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
        m_mis   = 1'b0;
        m_state = M_BOOT;
    endtask

    task automatic check_reset_values();
        chk1("rst_rd_en", imem_rd_en, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk1("rst_valid", if_valid, 1'b0);
        chk("rst_instr", if_instr, 32'h0000_0013);
        chk("rst_pc", if_pc, 32'h0);
        chk1("rst_misalign", misalign_err, 1'b0);
        chk("rst_count", fetch_count, 32'h0);
    endtask

    // Entered just after a rising edge; leaves just after the next one, in the BOOT cycle.
    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        halt = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One cycle: drive, sample at the falling edge, compare with the model, advance the model.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hlt);
        logic have;
        logic pop_m;
        logic exp_issue;
        if_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        halt = hlt;
        @(negedge clk);
        s_valid = if_valid;
        s_pc    = if_pc;
        s_instr = if_instr;
        s_addr  = imem_addr;
        s_rd    = imem_rd_en;
        s_mis   = misalign_err;
        have  = (q.size() > 0) && !rv;
        pop_m = have && rdy;
        exp_issue = (m_state == M_RUN) && !hlt && !rv && ((q.size() - int'(pop_m)) < 2);
        chk("imem_addr", imem_addr, m_pc);
        chk1("misalign_err", misalign_err, m_mis);
        chk("fetch_count", fetch_count, m_cnt);
        chk1("if_valid", if_valid, have);
        chk1("imem_rd_en", imem_rd_en, exp_issue);
        if (have) begin
            chk("if_pc", if_pc, q[0]);
            chk("if_instr", if_instr, 32'hA000_0000 | q[0]);
        end
        if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
        end else begin
            if (pop_m) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 32'd1;
            end
            if (exp_issue) begin
                q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        case (m_state)
            M_BOOT: m_state = M_RUN;
            M_RUN:  if (hlt) m_state = M_HALT;
            default: if (!hlt) m_state = M_RUN;
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic hlt_r;
        logic found;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        halt = 1'b0;
        if_ready = 1'b0;
        model_reset();
        #2;
        check_reset_values();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming from reset, then a 5-cycle stall with if_pc at 8.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk1("boot_no_issue", s_rd, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk1("first_issue", s_rd, 1'b1);
        chk1("first_valid_early", s_valid, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk1("first_valid", s_valid, 1'b1);
        chk("first_pc", s_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("second_pc", s_pc, 32'h4);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            chk("stall_pc", s_pc, 32'h8);
            chk("stall_instr", s_instr, 32'hA000_0008);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect to 0x40 while 0x10 is in flight.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("pre_redirect_addr", s_addr, 32'h10);
        step(1'b1, 1'b1, 32'h40, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk1("redirect_gap", s_valid, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("redirect_pc", s_pc, 32'h40);

        // Misaligned redirect.
        step(1'b1, 1'b1, 32'h42, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk1("misalign_set", s_mis, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("misalign_pc", s_pc, 32'h40);

        // Halt for 4 cycles while decode keeps draining.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            chk1("halt_no_issue", s_rd, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        chk1("misalign_sticky", s_mis, 1'b1);

        // Randomized traffic.
        hlt_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) hlt_r = ~hlt_r;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 32'($urandom_range(0, 511)), hlt_r);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Reset mid-stream with pc at 0x20.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            if (s_rd && s_addr == 32'h1C) found = 1'b1;
        end
        chk1("reach_pc_1c", found, 1'b1);
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("restart_addr", s_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("restart_pc", s_pc, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the instruction buffer entries; only value 2 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_rd_en  output  1  read strobe to Instruction_Memory.
REQ-006 SHALL have port imem_addr  output  32  read_address to Instruction_Memory.
REQ-007 SHALL have port imem_rdata  input  32  Instruction_out from Instruction_Memory, valid exactly 1 cycle after the strobe.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  32  redirect target.
REQ-010 SHALL have port halt  input  1  stop issuing new fetches.
REQ-011 SHALL have port if_valid  output  1  instruction available to decode.
REQ-012 SHALL have port if_ready  input  1  decode accepts the instruction.
REQ-013 SHALL have port if_instr  output  32  fetched instruction.
REQ-014 SHALL have port if_pc  output  32  address of if_instr.
REQ-015 SHALL have port misalign_err  output  1  sticky misaligned-redirect flag.
REQ-016 SHALL have port fetch_count  output  32  count of accepted instructions.

Function
REQ-017 SHALL implement FSM states BOOT (first cycle after reset release, no issue), RUN (issuing), HALTED (no issue); BOOT->RUN unconditionally, RUN->HALTED when halt=1, HALTED->RUN when halt=0.
REQ-018 SHALL, in RUN, issue a read (imem_rd_en=1, imem_addr=pc) whenever occupancy + in_flight − pop < 2, then set pc <= pc+4 (wrap from 32'hFFFF_FFFC to 0).
REQ-019 SHALL write each returning imem_rdata with its address into the 2-entry buffer one cycle after issue; latency issue->if_valid SHALL be 1 cycle when the buffer is empty.
REQ-020 SHALL sustain one instruction per cycle while if_ready=1 and no redirect/halt.
REQ-021 SHALL pop on if_valid && if_ready; if_valid, if_instr, if_pc SHALL hold stable while if_valid && !if_ready.
REQ-022 SHALL, on redirect_valid, flush the buffer, discard any in-flight response, set pc <= {redirect_pc[31:2],2'b00}, and suppress issue that cycle; redirect SHALL take priority over pop, issue and write.
REQ-023 SHALL issue the redirect target the cycle after redirect; first redirected if_valid SHALL appear 2 cycles after redirect_valid.
REQ-024 SHALL set misalign_err when redirect_valid && redirect_pc[1:0]!=0, held until reset.
REQ-025 SHALL let an in-flight read complete into the buffer when entering HALTED; redirect in HALTED SHALL update pc and flush without leaving HALTED.
REQ-026 SHALL drive imem_addr = pc when imem_rd_en=0.
REQ-027 SHALL increment fetch_count by 1 per pop, wrapping modulo 2^32.
REQ-028 SHALL ignore if_ready when if_valid=0; simultaneous pop and buffer write SHALL keep occupancy unchanged.

Reset
REQ-029 SHALL on reset asynchronously enter BOOT: pc=RESET_PC, occupancy=0, in_flight=0, imem_rd_en=0, imem_addr=RESET_PC, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, misalign_err=0, fetch_count=0.
REQ-030 SHALL drop any in-flight response when reset asserts mid-operation; no stale instruction SHALL appear after release.

Structure
REQ-031 SHALL place RESET_PC default, NOP encoding (32'h0000_0013), FSM state encodings and BUF_DEPTH in shared package fetch_pkg.
REQ-032 SHALL implement the buffer as sub-module fetch_skid_buffer (2-entry FIFO with flush, {pc,instr} payload).

Verification
REQ-033 SHALL cover: memory model mem[a]=32'hA000_0000|a, if_ready=1 from reset -> if_pc 0,4,8,C... on consecutive cycles, first if_valid 2 cycles after reset release.
REQ-034 SHALL cover: if_ready=0 for 5 cycles at if_pc=8 -> if_pc/if_instr held at 8/A000_0008, exactly 2 reads outstanding max, no lost/duplicate instruction on resume.
REQ-035 SHALL cover: redirect_valid with redirect_pc=32'h40 while 0x10 in flight -> 0x10 never presented, if_pc=0x40 appears 2 cycles later.
REQ-036 SHALL cover: redirect_pc=32'h42 -> misalign_err=1 and next if_pc=0x40; stays 1 until reset.
REQ-037 SHALL cover: halt=1 for 4 cycles -> no imem_rd_en, buffered instructions still drained; fetch_count equals number of handshakes.
REQ-038 SHALL cover: reset asserted mid-stream at pc=0x20 -> all outputs at reset values immediately; fetch restarts at RESET_PC.
